// File: rtl/if_fetch_unit_if.sv
// Split-transaction instruction memory port: request/grant address phase,
// single-pulse rvalid data phase.
interface if_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, instruction hold
// register feeding IF/ID, with redirect handling that drops in-flight responses.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IF_Stall,
    input  logic                   Redirect,
    input  logic [31:0]            RedirectPC,
    if_fetch_unit_if.master        im,
    output logic [31:0]            IF_PCplus4,
    output logic [5:0]             IF_OpCode,
    output logic [4:0]             IF_rs,
    output logic [4:0]             IF_rt,
    output logic [4:0]             IF_rd,
    output logic [4:0]             IF_Shamt,
    output logic [5:0]             IF_Funct,
    output logic                   IF_Bubble
);

    typedef enum logic [1:0] {REQ, RESP, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcp4_q, pcp4_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            pcp4_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcp4_q  <= pcp4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcp4_d  = pcp4_q;
        if (Redirect) begin
            // Redirect wins everywhere; a granted-but-unreturned request must
            // still have its response swallowed in DROP.
            pc_d = RedirectPC & ~32'h3;
            case (state_q)
                REQ:  state_d = im.im_gnt    ? DROP : REQ;
                RESP: state_d = im.im_rvalid ? REQ  : DROP;
                HOLD: state_d = REQ;
                DROP: state_d = im.im_rvalid ? REQ  : DROP;
            endcase
        end else begin
            case (state_q)
                REQ:  if (im.im_gnt) state_d = RESP;
                RESP: if (im.im_rvalid) begin
                    ir_d    = im.im_rdata;
                    pcp4_d  = pc_q + 32'd4;
                    pc_d    = pc_q + 32'd4;
                    state_d = HOLD;
                end
                HOLD: if (!IF_Stall) state_d = REQ;
                DROP: if (im.im_rvalid) state_d = REQ;
            endcase
        end
    end

    always_comb begin
        im.im_req  = (state_q == REQ);
        im.im_addr = pc_q;
        IF_Bubble  = (state_q != HOLD);
        IF_PCplus4 = pcp4_q;
        IF_OpCode  = '0;
        IF_rs      = '0;
        IF_rt      = '0;
        IF_rd      = '0;
        IF_Shamt   = '0;
        IF_Funct   = '0;
        if (state_q == HOLD) begin
            IF_OpCode = ir_q[31:26];
            IF_rs     = ir_q[25:21];
            IF_rt     = ir_q[20:16];
            IF_rd     = ir_q[15:11];
            IF_Shamt  = ir_q[10:6];
            IF_Funct  = ir_q[5:0];
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized memory/stall/redirect traffic against a model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] IF_PCplus4;
    logic [5:0]  IF_OpCode;
    logic [4:0]  IF_rs;
    logic [4:0]  IF_rt;
    logic [4:0]  IF_rd;
    logic [4:0]  IF_Shamt;
    logic [5:0]  IF_Funct;
    logic        IF_Bubble;

    if_fetch_unit_if imb();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .IF_Stall   (IF_Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .im         (imb),
        .IF_PCplus4 (IF_PCplus4),
        .IF_OpCode  (IF_OpCode),
        .IF_rs      (IF_rs),
        .IF_rt      (IF_rt),
        .IF_rd      (IF_rd),
        .IF_Shamt   (IF_Shamt),
        .IF_Funct   (IF_Funct),
        .IF_Bubble  (IF_Bubble)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: is an instruction held, is a read outstanding, is it killed.
    bit          m_hold, m_out, m_kill;
    logic [31:0] m_pc, m_word, m_pcp4;

    // Memory responder state
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] w;
        w = m_hold ? m_word : 32'h0;
        chk("im_req", {31'h0, imb.im_req}, {31'h0, (!m_hold && !m_out)});
        if (!m_hold && !m_out) chk("im_addr", imb.im_addr, m_pc);
        chk("IF_Bubble", {31'h0, IF_Bubble}, {31'h0, !m_hold});
        chk("IF_OpCode", {26'h0, IF_OpCode}, {26'h0, w[31:26]});
        chk("IF_rs", {27'h0, IF_rs}, {27'h0, w[25:21]});
        chk("IF_rt", {27'h0, IF_rt}, {27'h0, w[20:16]});
        chk("IF_rd", {27'h0, IF_rd}, {27'h0, w[15:11]});
        chk("IF_Shamt", {27'h0, IF_Shamt}, {27'h0, w[10:6]});
        chk("IF_Funct", {26'h0, IF_Funct}, {26'h0, w[5:0]});
        chk("IF_PCplus4", IF_PCplus4, m_pcp4);
    endtask

    task automatic model_reset();
        m_hold = 0; m_out = 0; m_kill = 0;
        m_pc = 32'h0; m_word = 32'h0; m_pcp4 = 32'h0;
        mem_pend = 0; mem_cnt = 0;
    endtask

    task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit g, input bit rv, input logic [31:0] data);
        if (!m_hold && !m_out) begin
            if (g) begin
                m_out  = 1;
                m_kill = rd;
            end
        end else if (m_out) begin
            if (rv) begin
                if (!m_kill && !rd) begin
                    m_hold = 1;
                    m_word = data;
                    m_pcp4 = m_pc + 32'd4;
                    m_pc   = m_pc + 32'd4;
                end
                m_out  = 0;
                m_kill = 0;
            end else if (rd) begin
                m_kill = 1;
            end
        end else if (m_hold) begin
            if (rd || !st) m_hold = 0;
        end
        if (rd) m_pc = rpc & ~32'h3;
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc,
                         input bit g, input bit rv, input logic [31:0] data);
        IF_Stall       = st;
        Redirect       = rd;
        RedirectPC     = rpc;
        imb.im_gnt     = g;
        imb.im_rvalid  = rv;
        imb.im_rdata   = data;
        @(posedge clk);
        model_edge(st, rd, rpc, g, rv, data);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int hold_cycles);
        reset         = 1'b0;
        IF_Stall      = 1'b0;
        Redirect      = 1'b0;
        RedirectPC    = 32'h0;
        imb.im_gnt    = 1'b0;
        imb.im_rvalid = 1'b0;
        imb.im_rdata  = 32'h0;
        #1;
        model_reset();
        compare_all();
        chk("rst_bubble", {31'h0, IF_Bubble}, 32'h1);
        chk("rst_req", {31'h0, imb.im_req}, 32'h1);
        repeat (hold_cycles) @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();
        chk("rst_addr", imb.im_addr, 32'h0);
    endtask

    bit          r_st, r_rd, r_g, r_rv, granted;
    logic [31:0] r_rpc, r_data;

    initial begin
        @(negedge clk);
        do_reset(1);

        // Fetch at reset PC, immediate grant, 1-cycle response
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'h012A4020);
        chk("t1_opcode", {26'h0, IF_OpCode}, 32'h0);
        chk("t1_rs", {27'h0, IF_rs}, 32'd9);
        chk("t1_rt", {27'h0, IF_rt}, 32'd10);
        chk("t1_rd", {27'h0, IF_rd}, 32'd8);
        chk("t1_funct", {26'h0, IF_Funct}, 32'h20);
        chk("t1_pcp4", IF_PCplus4, 32'h4);
        chk("t1_bubble", {31'h0, IF_Bubble}, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        chk("t1_next_addr", imb.im_addr, 32'h4);

        // Stall holds the instruction
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'h8D090004);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h0, 0, 0, 32'h0);
            chk("t2_opcode", {26'h0, IF_OpCode}, 32'h23);
            chk("t2_rt", {27'h0, IF_rt}, 32'd9);
            chk("t2_req", {31'h0, imb.im_req}, 32'h0);
        end
        chk("t2_pcp4", IF_PCplus4, 32'h8);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        chk("t2_next_addr", imb.im_addr, 32'h8);

        // Redirect during RESP: response dropped
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 1, 32'h00400103, 0, 0, 32'h0);
        chk("t3_drop_req", {31'h0, imb.im_req}, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'hDEADBEEF);
        chk("t3_bubble", {31'h0, IF_Bubble}, 32'h1);
        chk("t3_addr", imb.im_addr, 32'h00400100);

        // Redirect in HOLD with stall
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'h00000020);
        chk("t4_pcp4", IF_PCplus4, 32'h00400104);
        cycle(1, 1, 32'h00001000, 0, 0, 32'h0);
        chk("t4_bubble", {31'h0, IF_Bubble}, 32'h1);
        chk("t4_addr", imb.im_addr, 32'h00001000);

        // PC wrap
        cycle(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0);
        chk("t5_addr", imb.im_addr, 32'hFFFFFFFC);
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'h20000001);
        chk("t5_pcp4", IF_PCplus4, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        chk("t5_next_addr", imb.im_addr, 32'h0);

        // Reset mid-fetch
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        do_reset(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r_st  = ($urandom % 10) < 3;
            r_rd  = ($urandom % 12) == 0;
            r_rpc = (($urandom % 8) == 0) ? 32'hFFFFFFFF : $urandom;
            r_g   = ($urandom % 3) != 0;
            r_rv  = 0;
            if (mem_pend) begin
                if (mem_cnt == 0) r_rv = 1;
                else mem_cnt--;
            end
            r_data  = r_rv ? mem_data : $urandom;
            granted = r_g && !m_hold && !m_out;
            cycle(r_st, r_rd, r_rpc, r_g, r_rv, r_data);
            if (r_rv) mem_pend = 0;
            if (granted) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_data = $urandom;
            end
            if (($urandom % 700) == 0) begin
                @(negedge clk);
                do_reset(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
